// File: rtl/sdp_ram_axi_rd.sv
// Simple-dual-port RAM: native write port, AXI4 read-only slave with INCR bursts.
// A 2-entry output buffer behind the 1-cycle RAM read absorbs RREADY backpressure.
module sdp_ram_axi_rd #(
  parameter int unsigned DW       = 512,
  parameter int unsigned DD       = 16384,
  parameter string       RAM_TYPE = "ultra"
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              wea,
  input  logic [$clog2(DD)-1:0]             addra,
  input  logic [DW-1:0]                     dia,
  output logic                              burst_done,
  input  logic [$clog2(DD*(DW/8))-1:0]      S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  input  logic [3:0]                        S_AXI_ARID,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [3:0]                        S_AXI_ARQOS,
  input  logic [2:0]                        S_AXI_ARPROT,
  output logic                              S_AXI_ARREADY,
  output logic [DW-1:0]                     S_AXI_RDATA,
  output logic [3:0]                        S_AXI_RID,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [$clog2(DD*(DW/8))-1:0]      S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  input  logic [3:0]                        S_AXI_AWID,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [3:0]                        S_AXI_AWQOS,
  input  logic [2:0]                        S_AXI_AWPROT,
  output logic                              S_AXI_AWREADY,
  input  logic [DW-1:0]                     S_AXI_WDATA,
  input  logic [DW/8-1:0]                   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [3:0]                        S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY
);

  localparam int unsigned AW = $clog2(DD);
  localparam int unsigned BW = $clog2(DW / 8);
  localparam int unsigned XW = $clog2(DD * (DW / 8));

  typedef enum logic [1:0] {StInit, StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic            arready_q, arready_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [8:0]      remaining_q, remaining_d;
  logic [3:0]      rid_q, rid_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;
  logic [DW-1:0]   buf_data_q [2];
  logic [DW-1:0]   buf_data_d [2];
  logic [1:0]      buf_last_q, buf_last_d;
  logic            wr_idx_q, wr_idx_d;
  logic            rd_idx_q, rd_idx_d;
  logic [1:0]      count_q, count_d;
  logic            burst_done_q, burst_done_d;

  logic            issue, issue_last;
  logic [AW-1:0]   ram_raddr;
  logic [DW-1:0]   ram_dout_q;
  logic            rvalid, push, pop, ar_hs, head_last;
  logic [AW-1:0]   ar_word;
  logic [2:0]      slots_used;

  assign ar_word   = S_AXI_ARADDR[XW-1:BW];
  assign ar_hs     = S_AXI_ARVALID & arready_q;
  assign rvalid    = (count_q != 2'd0);
  assign head_last = buf_last_q[rd_idx_q];
  assign pop       = rvalid & S_AXI_RREADY;
  assign push      = inflight_q;
  // A beat leaving this cycle frees its slot before the issued read can land.
  assign slots_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // The first read is issued straight from ARADDR so the first beat is valid at N+2.
  always_comb begin
    state_d     = state_q;
    arready_d   = arready_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    rid_d       = rid_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    ram_raddr   = rd_ptr_q;
    unique case (state_q)
      StInit: begin
        arready_d = 1'b1;
        state_d   = StIdle;
      end
      StIdle: begin
        ram_raddr = ar_word;
        if (ar_hs) begin
          issue       = 1'b1;
          issue_last  = (S_AXI_ARLEN == 8'd0);
          rd_ptr_d    = ar_word + 1'b1;
          remaining_d = {1'b0, S_AXI_ARLEN};
          rid_d       = S_AXI_ARID;
          arready_d   = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (remaining_q != 9'd0 && slots_used < 3'd2) begin
          issue       = 1'b1;
          issue_last  = (remaining_q == 9'd1);
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
        if (remaining_q == 9'd0 && pop && head_last) begin
          arready_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    wr_idx_d        = wr_idx_q;
    rd_idx_d        = rd_idx_q;
    inflight_d      = issue;
    inflight_last_d = issue_last;
    burst_done_d    = pop & head_last;
    if (push) begin
      buf_data_d[wr_idx_q] = ram_dout_q;
      buf_last_d[wr_idx_q] = inflight_last_q;
      wr_idx_d             = ~wr_idx_q;
    end
    if (pop) begin
      rd_idx_d = ~rd_idx_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= StInit;
      arready_q       <= 1'b0;
      rd_ptr_q        <= '0;
      remaining_q     <= '0;
      rid_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_last_q      <= '0;
      wr_idx_q        <= 1'b0;
      rd_idx_q        <= 1'b0;
      count_q         <= '0;
      burst_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      arready_q       <= arready_d;
      rd_ptr_q        <= rd_ptr_d;
      remaining_q     <= remaining_d;
      rid_q           <= rid_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_last_q      <= buf_last_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      count_q         <= count_d;
      burst_done_q    <= burst_done_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
  end

  if (RAM_TYPE == "ultra") begin : g_uram
    (* ram_style = "ultra" *) logic [DW-1:0] mem [DD];
    always_ff @(posedge clk) begin
      if (wea) mem[addra] <= dia;
    end
    always_ff @(posedge clk) begin
      if (issue) ram_dout_q <= mem[ram_raddr];
    end
  end else begin : g_bram
    (* ram_style = "block" *) logic [DW-1:0] mem [DD];
    always_ff @(posedge clk) begin
      if (wea) mem[addra] <= dia;
    end
    always_ff @(posedge clk) begin
      if (issue) ram_dout_q <= mem[ram_raddr];
    end
  end

  assign burst_done    = burst_done_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = buf_data_q[rd_idx_q];
  assign S_AXI_RID     = rid_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RLAST   = rvalid & head_last;
  assign S_AXI_RVALID  = rvalid;

  // Write channels are tied off; the RAM is written only through the native port.
  assign S_AXI_AWREADY = 1'b0;
  assign S_AXI_WREADY  = 1'b0;
  assign S_AXI_BID     = 4'd0;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_ARADDR[BW-1:0], S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
                           S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_AWADDR,
                           S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE,
                           S_AXI_AWBURST, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS,
                           S_AXI_AWPROT, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
                           S_AXI_WVALID, S_AXI_BREADY};

endmodule

// File: tb/tb_sdp_ram_axi_rd.sv
// Scoreboard bench for sdp_ram_axi_rd: expected beats queued at AR time, checked on R.
module tb_sdp_ram_axi_rd;

  localparam int unsigned DW = 512;
  localparam int unsigned DD = 16384;
  localparam int unsigned AW = $clog2(DD);
  localparam int unsigned XW = $clog2(DD * (DW / 8));

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    id;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           resetn;
  logic           wea;
  logic [AW-1:0]  addra;
  logic [DW-1:0]  dia;
  logic           burst_done;
  logic [XW-1:0]  araddr;
  logic           arvalid;
  logic [3:0]     arid;
  logic [7:0]     arlen;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [3:0]     rid;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic [XW-1:0]  awaddr;
  logic           awvalid;
  logic           awready;
  logic [DW-1:0]  wdata;
  logic           wlast;
  logic           wvalid;
  logic           wready;
  logic [3:0]     bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;

  sdp_ram_axi_rd #(.DW(DW), .DD(DD), .RAM_TYPE("ultra")) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wea           (wea),
    .addra         (addra),
    .dia           (dia),
    .burst_done    (burst_done),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARID    (arid),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARSIZE  (3'd6),
    .S_AXI_ARBURST (2'b01),
    .S_AXI_ARLOCK  (1'b0),
    .S_AXI_ARCACHE (4'd0),
    .S_AXI_ARQOS   (4'd0),
    .S_AXI_ARPROT  (3'd0),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RID     (rid),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWID    (4'd3),
    .S_AXI_AWLEN   (8'd0),
    .S_AXI_AWSIZE  (3'd6),
    .S_AXI_AWBURST (2'b01),
    .S_AXI_AWLOCK  (1'b0),
    .S_AXI_AWCACHE (4'd0),
    .S_AXI_AWQOS   (4'd0),
    .S_AXI_AWPROT  (3'd0),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   ({(DW/8){1'b1}}),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BID     (bid),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] model [DD];
  int            beats_seen = 0;
  int            bd_count = 0;
  int            rlast_cyc = 0;
  int            hs_cyc = 0;
  bit            lat_pending = 1'b0;
  bit            exp_bd = 1'b0;
  bit            rr_toggle = 1'b0;
  logic [3:0]    rr_pat = 4'b1001;
  logic [1:0]    rr_ph = 2'd0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sole driver of RREADY: held high, or cycling 1,0,0,1 when toggling.
  always @(posedge clk) begin
    #1;
    if (rr_toggle) begin
      rready = rr_pat[rr_ph];
      rr_ph  = rr_ph + 2'd1;
    end else begin
      rready = 1'b1;
    end
  end

  // Head of R must always match the next expected beat, stalled or not.
  always @(negedge clk) begin
    bit    popped_last;
    beat_t e;
    popped_last = 1'b0;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("rvalid_unexpected", rvalid, 1'b0);
      end else begin
        e = exp_q[0];
        check_eq("rdata", rdata, e.data);
        check_eq("rid", rid, e.id);
        check_eq("rlast", rlast, e.last);
        check_eq("rresp", rresp, 2'b00);
        if (lat_pending) begin
          check_eq("first_beat_latency", cyc - hs_cyc, 2);
          lat_pending = 1'b0;
        end
        if (rready) begin
          void'(exp_q.pop_front());
          beats_seen++;
          popped_last = e.last;
          if (e.last) rlast_cyc = cyc;
        end
      end
    end
    if (burst_done) bd_count++;
    if (burst_done || exp_bd) check_eq("burst_done", burst_done, exp_bd);
    exp_bd = popped_last;
    if (!resetn) begin
      exp_q.delete();
      exp_bd      = 1'b0;
      lat_pending = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end at posedge+1.
  task automatic wr(input int unsigned a, input logic [DW-1:0] d);
    wea   = 1'b1;
    addra = AW'(a);
    dia   = d;
    model[a] = d;
    @(posedge clk); #1;
    wea = 1'b0;
  endtask

  task automatic do_ar(input int unsigned word, input int unsigned lowb, input int unsigned len,
                       input logic [3:0] id);
    bit    ok;
    beat_t b;
    araddr  = XW'(word * (DW / 8) + lowb);
    arlen   = 8'(len);
    arid    = id;
    arvalid = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = model[(word + i) % DD];
      b.id   = id;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("ar_timeout", arready, 1'b1);
    hs_cyc      = cyc;
    lat_pending = ok;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", DW'(exp_q.size()), '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int bd0;
    int b0;
    bit ok;
    resetn = 1'b0; wea = 1'b0; addra = '0; dia = '0;
    araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arready", arready, 1'b0);
    check_eq("rst_rvalid", rvalid, 1'b0);
    check_eq("rst_rlast", rlast, 1'b0);
    check_eq("rst_burst_done", burst_done, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("arready_after_release", arready, 1'b1);

    // 1: 16-beat burst with RREADY held high
    for (int k = 0; k < 16; k++) wr(k, DW'(k + 'h100));
    bd0 = bd_count;
    do_ar(0, 0, 15, 4'd5);
    wait_drain();
    check_eq("t1_burst_done_count", bd_count - bd0, 1);

    // 2: same burst with RREADY toggling 1,0,0,1
    rr_toggle = 1'b1;
    bd0 = bd_count;
    do_ar(0, 0, 15, 4'd5);
    wait_drain();
    rr_toggle = 1'b0;
    check_eq("t2_burst_done_count", bd_count - bd0, 1);

    // 3: wrap from DD-2 to 1; low byte-address bits must be ignored
    wr(DD - 2, DW'('hAAA0));
    wr(DD - 1, DW'('hAAA1));
    do_ar(DD - 2, 5, 3, 4'd3);
    wait_drain();

    // 4: back-to-back ARs, second held valid while the first is in progress
    do_ar(2, 0, 0, 4'd1);
    check_eq("t4_arready_low_in_burst", arready, 1'b0);
    do_ar(3, 0, 7, 4'd2);
    check_eq("t4_accept_after_rlast", hs_cyc - rlast_cyc, 1);
    wait_drain();

    // 5: reset for one cycle at beat 3 of a long burst
    b0 = beats_seen;
    do_ar(0, 0, 15, 4'd6);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (beats_seen >= b0 + 3) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check_eq("t5_beat_timeout", 1'b0, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_rvalid_after_reset", rvalid, 1'b0);
    check_eq("t5_arready_in_reset", arready, 1'b0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_arready_after_release", arready, 1'b1);
    check_eq("t5_rvalid_idle", rvalid, 1'b0);
    do_ar(4, 0, 1, 4'd9);
    wait_drain();

    // 6: AW/W traffic is refused and leaves the RAM untouched
    awaddr  = '0;
    awvalid = 1'b1;
    wdata   = '1;
    wlast   = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t6_awready", awready, 1'b0);
      check_eq("t6_wready", wready, 1'b0);
      check_eq("t6_bvalid", bvalid, 1'b0);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    do_ar(0, 0, 3, 4'd7);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
